// File: rtl/mcpu_ifetch.sv
// rtl/mcpu_ifetch.sv - dual-port ROM prefetch into a byte FIFO feeding decode
// Optional feature macro: MCPU_IFETCH_STALL_CNT_EN (adds stall_cnt/jump_cnt outputs)
module mcpu_ifetch #(
    parameter int IROM_ADDR_BITS = 14,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [IROM_ADDR_BITS-1:0] irom_addr0,
    output logic [IROM_ADDR_BITS-1:0] irom_addr1,
    input  logic [7:0]                irom_out0,
    input  logic [7:0]                irom_out1,
    output logic [7:0]                op_byte,
    output logic [7:0]                arg_byte,
    output logic                      op_valid,
    output logic                      arg_valid,
    output logic [IROM_ADDR_BITS-1:0] op_addr,
    input  logic                      take,
    input  logic                      take_len,
    input  logic                      jump_en,
    input  logic [IROM_ADDR_BITS-1:0] jump_addr,
`ifdef MCPU_IFETCH_STALL_CNT_EN
    output logic [15:0]               stall_cnt,
    output logic [15:0]               jump_cnt,
`endif
    output logic [1:0]                state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_REFILL = 2'd0,
        ST_RUN    = 2'd1
    } state_t;

    state_t                      state_q;
    logic [IROM_ADDR_BITS-1:0]   fetch_pc;
    logic [7:0]                  mem [FIFO_DEPTH];
    logic [PW-1:0]               rd_ptr;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr_p1;
    logic [PW-1:0]               wr_ptr_p1;
    logic [CW-1:0]               count;
    logic [CW-1:0]               free;
    logic [CW-1:0]               push_n;
    logic [CW-1:0]               pop_n;
    logic [CW-1:0]               count_next;
    logic                        pop_ok;

    assign irom_addr0 = fetch_pc;
    assign irom_addr1 = fetch_pc + IROM_ADDR_BITS'(1);
    assign rd_ptr_p1  = rd_ptr + PW'(1);
    assign wr_ptr_p1  = wr_ptr + PW'(1);
    assign op_byte    = mem[rd_ptr];
    assign arg_byte   = mem[rd_ptr_p1];
    assign op_valid   = (count != '0);
    assign arg_valid  = (count >= CW'(2));
    assign state      = state_q;

    // Push amount depends only on start-of-cycle occupancy, so a pop never makes room for this cycle's push.
    always_comb begin
        free       = CW'(FIFO_DEPTH) - count;
        push_n     = '0;
        if (free >= CW'(2)) begin
            push_n = CW'(2);
        end else if (free == CW'(1)) begin
            push_n = CW'(1);
        end
        pop_ok     = take && (take_len ? arg_valid : op_valid);
        pop_n      = pop_ok ? (take_len ? CW'(2) : CW'(1)) : '0;
        count_next = count + push_n - pop_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= '0;
            op_addr  <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            state_q  <= ST_REFILL;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (jump_en) begin
            fetch_pc <= jump_addr;
            op_addr  <= jump_addr;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            state_q  <= ST_REFILL;
        end else begin
            if (push_n != '0) begin
                mem[wr_ptr] <= irom_out0;
            end
            if (push_n == CW'(2)) begin
                mem[wr_ptr_p1] <= irom_out1;
            end
            wr_ptr   <= wr_ptr + push_n[PW-1:0];
            rd_ptr   <= rd_ptr + pop_n[PW-1:0];
            fetch_pc <= fetch_pc + IROM_ADDR_BITS'(push_n);
            op_addr  <= op_addr + IROM_ADDR_BITS'(pop_n);
            count    <= count_next;
            case (state_q)
                ST_REFILL: state_q <= (count_next >= CW'(2)) ? ST_RUN : ST_REFILL;
                ST_RUN:    state_q <= (count_next <  CW'(2)) ? ST_REFILL : ST_RUN;
                default:   state_q <= ST_REFILL;
            endcase
        end
    end

`ifdef MCPU_IFETCH_STALL_CNT_EN
    // Stall is judged on legality alone, so it is counted even when a jump discards the cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            jump_cnt  <= '0;
        end else begin
            if (take && !pop_ok && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (jump_en && (jump_cnt != 16'hFFFF)) begin
                jump_cnt <= jump_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
